// File: rtl/rv32_mem_pkg.sv
// Shared types and constants for the RV32 memory responder slice.
package rv32_mem_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned WAIT_CNT_W  = 4;
  localparam int unsigned MEMORY_SIZE = 256;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_t;

  // Full 32-bit compare so aliased upper bits never hit a real word.
  function automatic logic addr_in_range(input logic [WORD_W-1:0] addr,
                                         input int unsigned       words);
    return addr < WORD_W'(words);
  endfunction

endpackage

// File: rtl/rv32_mem_array.sv
// Word storage with two write ports (port A has priority) and two
// write-first combinational read ports.
module rv32_mem_array
  import rv32_mem_pkg::*;
#(
  parameter int unsigned WORDS = 256,
  parameter int unsigned AW    = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wa_en_i,
  input  logic [AW-1:0]     wa_addr_i,
  input  logic [WORD_W-1:0] wa_data_i,
  input  logic              wb_en_i,
  input  logic [AW-1:0]     wb_addr_i,
  input  logic [WORD_W-1:0] wb_data_i,
  input  logic [AW-1:0]     ra_addr_i,
  output logic [WORD_W-1:0] ra_data_o,
  input  logic [AW-1:0]     rb_addr_i,
  output logic [WORD_W-1:0] rb_data_o
);

  logic [WORD_W-1:0] mem_q [WORDS];

  // Port A is written last so it wins a same-index collision.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < WORDS; i++) mem_q[i] <= '0;
    end else begin
      if (wb_en_i) mem_q[wb_addr_i] <= wb_data_i;
      if (wa_en_i) mem_q[wa_addr_i] <= wa_data_i;
    end
  end

  always_comb begin
    ra_data_o = mem_q[ra_addr_i];
    if (wb_en_i && wb_addr_i == ra_addr_i) ra_data_o = wb_data_i;
    if (wa_en_i && wa_addr_i == ra_addr_i) ra_data_o = wa_data_i;
  end

  always_comb begin
    rb_data_o = mem_q[rb_addr_i];
    if (wb_en_i && wb_addr_i == rb_addr_i) rb_data_o = wb_data_i;
    if (wa_en_i && wa_addr_i == rb_addr_i) rb_data_o = wa_data_i;
  end

endmodule

// File: rtl/rv32_mem_responder.sv
// Instruction/data memory responder for the RV32 core with a side loader.
// Define RV32_MEM_TRACE_EN to print a simulation trace of every access.
module rv32_mem_responder
  import rv32_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS   = MEMORY_SIZE,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_data_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ready_o,
  input  logic        load_we_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_data_i,
  output logic        err_o
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  mem_state_t            state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           instr_data_q, mem_data_q;
  logic                  err_q;

  logic        acc_fire, acc_we;
  logic [31:0] acc_addr, acc_wdata;

  // With no wait states the access uses the live request on its accept edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    acc_fire  = 1'b0;
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    case (state_q)
      IDLE: begin
        if (mem_req_i) begin
          we_d    = mem_we_i;
          addr_d  = mem_addr_i;
          wdata_d = mem_data_i;
          if (WAIT_CYCLES == 0) begin
            acc_fire  = 1'b1;
            acc_we    = mem_we_i;
            acc_addr  = mem_addr_i;
            acc_wdata = mem_data_i;
            state_d   = RESP;
          end else begin
            cnt_d   = WAIT_CNT_W'(WAIT_CYCLES);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - WAIT_CNT_W'(1);
        if (cnt_q == WAIT_CNT_W'(1)) begin
          acc_fire = 1'b1;
          state_d  = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic instr_ok, load_ok, acc_ok;
  logic load_wr, dwr_raw, clash, dwr, drd, err_set;

  assign instr_ok = addr_in_range(instr_addr_i, MEM_WORDS);
  assign load_ok  = addr_in_range(load_addr_i, MEM_WORDS);
  assign acc_ok   = addr_in_range(acc_addr, MEM_WORDS);
  assign load_wr  = load_we_i && load_ok;
  assign dwr_raw  = acc_fire && acc_we && acc_ok;
  assign clash    = load_wr && dwr_raw && (load_addr_i == acc_addr);
  assign dwr      = dwr_raw && !clash;
  assign drd      = acc_fire && !acc_we;
  assign err_set  = (load_we_i && !load_ok) || (acc_fire && !acc_ok) || clash || !instr_ok;

  logic [31:0] rd_instr, rd_data;

  rv32_mem_array #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_array (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wa_en_i   (load_wr),
    .wa_addr_i (load_addr_i[AW-1:0]),
    .wa_data_i (load_data_i),
    .wb_en_i   (dwr),
    .wb_addr_i (acc_addr[AW-1:0]),
    .wb_data_i (acc_wdata),
    .ra_addr_i (instr_addr_i[AW-1:0]),
    .ra_data_o (rd_instr),
    .rb_addr_i (acc_addr[AW-1:0]),
    .rb_data_o (rd_data)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      instr_data_q <= '0;
      mem_data_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      instr_data_q <= instr_ok ? rd_instr : '0;
      if (drd) mem_data_q <= acc_ok ? rd_data : '0;
      err_q        <= err_q | err_set;
    end
  end

  assign instr_data_o = instr_data_q;
  assign mem_data_o   = mem_data_q;
  assign mem_ready_o  = (state_q == RESP);
  assign err_o        = err_q;

`ifdef RV32_MEM_TRACE_EN
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (load_wr)
        $display("%0t L idx=%0d data=%h", $time, load_addr_i, load_data_i);
      if (load_we_i && !load_ok)
        $display("%0t ERR L out of range idx=%0d", $time, load_addr_i);
      if (dwr)
        $display("%0t D idx=%0d data=%h", $time, acc_addr, acc_wdata);
      if (drd && acc_ok)
        $display("%0t D read idx=%0d data=%h", $time, acc_addr, rd_data);
      if (acc_fire && !acc_ok)
        $display("%0t ERR D out of range idx=%0d", $time, acc_addr);
      if (clash)
        $display("%0t ERR D write dropped, loader collision idx=%0d", $time, acc_addr);
      if (!instr_ok)
        $display("%0t ERR I out of range idx=%0d", $time, instr_addr_i);
    end
  end
`endif

endmodule

// File: doc/rv32_mem_responder.md
Name: rv32_mem_responder

Overview:
- Word-addressed memory responder that serves the RV32 core on two ports.
- Instruction port: read-only, fixed 1-cycle latency, no handshake.
- Data port: read/write behind a req/ready handshake, with a parameterised number of wait states.
- Side loader port lets the testbench preload the program and data images. Sits between the core and the tb, replacing ad-hoc tb memory arrays.

Parameters:
- MEM_WORDS, default MEMORY_SIZE (tb_constants): number of 32-bit words; power of two, at least 2.
- WAIT_CYCLES, default 0: extra cycles between data request accept and data access; 0..15.

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- instr_addr_i  in  32  instruction word index
- instr_data_o  out  32  instruction word read from instr_addr_i
- mem_req_i  in  1  data request valid
- mem_we_i  in  1  1 = write, 0 = read (qualified by mem_req_i)
- mem_addr_i  in  32  data word index
- mem_data_i  in  32  write data
- mem_data_o  out  32  read data
- mem_ready_o  out  1  one-cycle completion pulse
- load_we_i  in  1  loader write strobe
- load_addr_i  in  32  loader word index
- load_data_i  in  32  loader write data
- err_o  out  1  sticky error flag

Behaviour:
- Reset (async, active-high):
  - all memory words = 0; FSM = IDLE; wait counter = 0.
  - instr_data_o = 0, mem_data_o = 0, mem_ready_o = 0, err_o = 0.
  - Any in-flight access is discarded, so a pending write is never committed.
- Address range:
  - Index valid iff addr < MEM_WORDS; the full 32 bits are compared.
  - Out-of-range read returns 0. Out-of-range write is dropped.
  - Either case sets err_o; err_o is cleared only by reset.
- Instruction port:
  - Every edge: instr_data_o <= mem[instr_addr_i].
  - Latency 1 cycle, no stall.
- Data FSM states: IDLE, WAIT, RESP.
  - IDLE, mem_req_i = 1: capture we, addr and wdata.
    - If WAIT_CYCLES == 0: perform the access on this edge and go to RESP.
    - Otherwise: cnt <= WAIT_CYCLES and go to WAIT.
  - WAIT: cnt <= cnt - 1. When cnt == 1, perform the access and go to RESP.
  - RESP: mem_ready_o = 1 for exactly this cycle, then IDLE. mem_req_i is ignored in RESP and WAIT.
  - Back-to-back requests therefore complete every WAIT_CYCLES + 2 cycles.
- Data access:
  - Read: mem_data_o <= mem[addr]. mem_data_o holds its value until the next read completes; writes do not change it.
  - Write: mem[addr] <= wdata.
- Latency: a request sampled at edge N raises mem_ready_o in the cycle after edge N + WAIT_CYCLES.
- Collisions on the same edge:
  - Data write commit and instruction read to the same index: instr_data_o returns the new data (write-first).
  - Loader write and instruction read to the same index: write-first, same as above.
  - Loader write and data write commit to the same index: loader wins, the data write is dropped, err_o is set.
  - Loader write and data read commit to the same index: the read returns load_data_i.
- Loader:
  - load_we_i writes on any edge regardless of FSM state.
  - Range rules apply (out-of-range load is dropped and sets err_o).

Optional Feature:
- Macro: RV32_MEM_TRACE_EN.
- Defined: each committed data write, loader write and completed data read prints a $display line with $time, source (D/L), index and data. Every dropped access prints "ERR" plus the reason. Simulation-only code, no functional change.
- Undefined: no display statements are compiled.

Decomposition:
- Shared package rv32_mem_pkg:
  - FSM state enum mem_state_t (IDLE, WAIT, RESP).
  - WAIT_CNT_W = 4.
  - Word width constant 32.
  - Function addr_in_range(addr, words).
- Sub-module rv32_mem_array: storage plus the write-first read mux, with two write ports (loader priority) and two read ports.
- rv32_mem_responder keeps the FSM, range checks, error flag and trace.

Test Plan:
1. Loader writes 0x00A00093 to index 255 with MEM_WORDS = 256 → instr_addr_i = 255 gives instr_data_o = 0x00A00093 one cycle later.
2. WAIT_CYCLES = 0: data write 0xDEADBEEF to index 128, then read index 128 → mem_ready_o pulses 1 cycle after each request edge; read returns 0xDEADBEEF.
3. WAIT_CYCLES = 3: read request at edge N → mem_ready_o high only in the cycle after edge N + 3. mem_req_i toggled during WAIT has no effect.
4. Data write 0x11111111 and loader write 0x22222222 committing to index 5 on the same edge → mem[5] = 0x22222222, err_o = 1. A same-edge instruction read of index 5 returns 0x22222222.
5. Read of index 300 (MEM_WORDS = 256) → mem_data_o = 0, mem_ready_o pulses, err_o = 1 and stays high.
6. Assert rst_i during WAIT of a write 0x5 to index 7 → mem_ready_o = 0 immediately. After release, index 7 reads 0 and err_o = 0.
